// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: fetch FSM encoding and
// instruction-stream constants.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4,
    TRAP   = 3'd5
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // JALR semantics: the architectural target always has bit 0 cleared.
  function automatic logic [31:0] clearBit0(input logic [31:0] addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer; presents each
// fetched word to execute for one cycle and counts retired instructions.
module pc_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NextPCSrc,
  input  logic [31:0] ALURes,
  input  logic        Halt,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemData,
  output logic        InstValid,
  output logic [31:0] Inst,
  output logic [31:0] PC,
  output logic [31:0] PCInc,
  output logic        MisalignTrap,
  output logic [31:0] TrapPC,
  output logic        Halted,
  output logic [31:0] RetireCount
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic         r_imemReq;
  logic         r_instValid;
  logic         r_misalign;
  logic [31:0]  r_trapPC;
  logic         r_halted;
  logic [31:0]  r_retire;

  fetch_state_t w_nextState;
  logic [31:0]  w_nextPC;
  logic [31:0]  w_nextInst;
  logic         w_nextMisalign;
  logic [31:0]  w_nextTrapPC;
  logic [31:0]  w_nextRetire;
  logic [31:0]  w_pcInc;
  logic [31:0]  w_target;

  assign w_pcInc  = r_pc + INSTR_BYTES;
  assign w_target = NextPCSrc ? clearBit0(ALURes) : w_pcInc;

  // Next-state logic; registered outputs are derived from the next state so
  // that ImemReq/InstValid/Halted line up exactly with REQ/EXEC/HALTED.
  always_comb begin
    w_nextState    = r_state;
    w_nextPC       = r_pc;
    w_nextInst     = r_inst;
    w_nextMisalign = r_misalign;
    w_nextTrapPC   = r_trapPC;
    w_nextRetire   = r_retire;
    case (r_state)
      IDLE: w_nextState = REQ;
      REQ:  w_nextState = WAIT;
      WAIT: begin
        if (ImemValid) begin
          w_nextInst  = ImemData;
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        if (NextPCSrc && w_target[1]) begin
          w_nextMisalign = 1'b1;
          w_nextTrapPC   = w_target;
          w_nextState    = TRAP;
        end else begin
          w_nextPC     = w_target;
          w_nextRetire = r_retire + 32'd1;
          w_nextState  = Halt ? HALTED : REQ;
        end
      end
      HALTED: w_nextState = HALTED;
      TRAP:   w_nextState = TRAP;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_inst      <= NOP_INSTR;
      r_imemReq   <= 1'b0;
      r_instValid <= 1'b0;
      r_misalign  <= 1'b0;
      r_trapPC    <= 32'h0000_0000;
      r_halted    <= 1'b0;
      r_retire    <= 32'h0000_0000;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPC;
      r_inst      <= w_nextInst;
      r_imemReq   <= (w_nextState == REQ);
      r_instValid <= (w_nextState == EXEC);
      r_misalign  <= w_nextMisalign;
      r_trapPC    <= w_nextTrapPC;
      r_halted    <= (w_nextState == HALTED);
      r_retire    <= w_nextRetire;
    end
  end

  assign ImemReq      = r_imemReq;
  assign ImemAddr     = r_pc;
  assign InstValid    = r_instValid;
  assign Inst         = r_inst;
  assign PC           = r_pc;
  assign PCInc        = w_pcInc;
  assign MisalignTrap = r_misalign;
  assign TrapPC       = r_trapPC;
  assign Halted       = r_halted;
  assign RetireCount  = r_retire;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small instruction-memory responder
// and a scoreboard of expected PC/instruction pairs.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        NextPCSrc = 1'b0;
  logic [31:0] ALURes = 32'h0;
  logic        Halt = 1'b0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid = 1'b0;
  logic [31:0] ImemData = 32'h0;
  logic        InstValid;
  logic [31:0] Inst;
  logic [31:0] PC;
  logic [31:0] PCInc;
  logic        MisalignTrap;
  logic [31:0] TrapPC;
  logic        Halted;
  logic [31:0] RetireCount;

  int checks = 0;
  int errors = 0;
  logic [31:0] expPcQ[$];
  logic [31:0] expInstQ[$];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .ALURes(ALURes), .Halt(Halt),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemValid(ImemValid), .ImemData(ImemData),
    .InstValid(InstValid), .Inst(Inst), .PC(PC), .PCInc(PCInc),
    .MisalignTrap(MisalignTrap), .TrapPC(TrapPC), .Halted(Halted), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrFor(input logic [31:0] addr);
    return {addr[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_pc"}, PC, 32'h0);
    check({tag, "_addr"}, ImemAddr, 32'h0);
    check({tag, "_pcinc"}, PCInc, 32'h4);
    check({tag, "_req"}, ImemReq, 32'h0);
    check({tag, "_ivalid"}, InstValid, 32'h0);
    check({tag, "_inst"}, Inst, 32'h0000_0013);
    check({tag, "_trap"}, MisalignTrap, 32'h0);
    check({tag, "_trappc"}, TrapPC, 32'h0);
    check({tag, "_halted"}, Halted, 32'h0);
    check({tag, "_retire"}, RetireCount, 32'h0);
  endtask

  // Holds reset, releases it just after a rising edge, checks the IDLE cycle
  // and leaves the bench at the negedge where the first request is expected.
  task automatic applyReset();
    rst = 1'b1;
    NextPCSrc = 1'b0; ALURes = 32'h0; Halt = 1'b0; ImemValid = 1'b0; ImemData = 32'h0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_req", ImemReq, 32'h0);
    @(negedge clk);
  endtask

  // One full instruction: wait for the request, respond after `latency` WAIT
  // cycles, check the EXEC cycle against the scoreboard and drive the branch
  // unit inputs for that cycle. Returns at the negedge after EXEC.
  task automatic applyStimulus(input logic [31:0] expAddr, input int latency, input bit spurious,
                               input bit src, input logic [31:0] alu, input bit halt,
                               input int expWait);
    int waited = 0;
    logic [31:0] gotPc;
    logic [31:0] gotInst;
    while (ImemReq !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_spacing", waited, expWait);
    check("req_addr", ImemAddr, expAddr);
    expPcQ.push_back(expAddr);
    expInstQ.push_back(instrFor(expAddr));
    if (spurious) begin
      ImemValid = 1'b1;
      ImemData  = 32'hDEAD_BEEF;
    end
    for (int i = 1; i < latency; i++) begin
      @(negedge clk);
      ImemValid = 1'b0;
      check("wait_ivalid", InstValid, 32'h0);
    end
    @(negedge clk);
    ImemValid = 1'b1;
    ImemData  = instrFor(expAddr);
    @(negedge clk);
    ImemValid = 1'b0;
    ImemData  = 32'h0;
    checkOutput();
    NextPCSrc = src;
    ALURes    = alu;
    Halt      = halt;
    @(negedge clk);
    check("ivalid_one_cycle", InstValid, 32'h0);
    NextPCSrc = 1'b0;
    ALURes    = 32'h0;
    Halt      = 1'b0;
  endtask

  task automatic checkOutput();
    logic [31:0] ePc;
    logic [31:0] eInst;
    check("exec_ivalid", InstValid, 32'h1);
    if (expPcQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      ePc   = expPcQ.pop_front();
      eInst = expInstQ.pop_front();
      check("exec_pc", PC, ePc);
      check("exec_inst", Inst, eInst);
      check("exec_pcinc", PCInc, ePc + 32'd4);
    end
  endtask

  task automatic checkNoRequests(input string tag, input int cycles);
    int reqs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ImemReq !== 1'b0) reqs++;
    end
    check(tag, reqs, 32'h0);
  endtask

  initial begin
    // Sequential fetch, halt on the third instruction
    applyReset();
    applyStimulus(32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'h4, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'h8, 1, 1'b0, 1'b0, 32'h0, 1'b1, 0);
    check("halt_halted", Halted, 32'h1);
    check("halt_pc", PC, 32'hC);
    check("halt_retire", RetireCount, 32'd3);
    check("halt_req", ImemReq, 32'h0);
    checkNoRequests("halt_no_req", 5);
    check("halt_sticky", Halted, 32'h1);

    // Branch, JALR bit-0 clear, slow memory with spurious strobe, misaligned target
    applyReset();
    applyStimulus(32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'h4, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'h8, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'hC, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'h10, 1, 1'b0, 1'b1, 32'h40, 1'b0, 0);
    applyStimulus(32'h40, 1, 1'b0, 1'b1, 32'h81, 1'b0, 0);
    check("jalr_no_trap", MisalignTrap, 32'h0);
    applyStimulus(32'h80, 5, 1'b1, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'h84, 1, 1'b0, 1'b1, 32'h22, 1'b1, 0);
    check("trap_flag", MisalignTrap, 32'h1);
    check("trap_pc", TrapPC, 32'h22);
    check("trap_halted", Halted, 32'h0);
    check("trap_pc_held", PC, 32'h84);
    check("trap_retire", RetireCount, 32'd7);
    checkNoRequests("trap_no_req", 5);
    check("trap_sticky", MisalignTrap, 32'h1);

    // PC wrap at the top of the address space, then async reset mid-WAIT
    applyReset();
    applyStimulus(32'h0, 1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 0);
    applyStimulus(32'hFFFF_FFFC, 2, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    applyStimulus(32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("wrap_retire", RetireCount, 32'd3);
    check("abort_req", ImemReq, 32'h1);
    check("abort_addr", ImemAddr, 32'h4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues("async");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("restart_idle_req", ImemReq, 32'h0);
    @(negedge clk);
    applyStimulus(32'h0, 1, 1'b0, 1'b0, 32'h0, 1'b0, 0);
    check("restart_next_addr", ImemAddr, 32'h4);
    check("restart_retire", RetireCount, 32'd1);
    check("scoreboard_drained", expPcQ.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the single-issue RV32I core. It holds the PC and issues one instruction-memory request at a time. It presents each fetched instruction to decode/execute for exactly one cycle. It consumes NextPCSrc from the branch unit and the ALU-computed target to choose the next PC. It also detects misaligned control-flow targets, supports halt, and counts retired instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- NextPCSrc  in  1  from branch unit; 1 = take ALURes target, 0 = PC+4
- ALURes  in  32  branch/JAL/JALR target from ALU
- Halt  in  1  stop fetching after the current instruction retires
- ImemReq  out  1  one-cycle request pulse to instruction memory
- ImemAddr  out  32  request address, always equal to PC
- ImemValid  in  1  response strobe from instruction memory
- ImemData  in  32  response instruction word
- InstValid  out  1  Inst/PC valid for execute this cycle
- Inst  out  32  current instruction
- PC  out  32  address of current instruction
- PCInc  out  32  PC+4, used as the link value
- MisalignTrap  out  1  sticky misaligned-target flag
- TrapPC  out  32  offending target address
- Halted  out  1  halted indicator
- RetireCount  out  32  retired-instruction counter

## Operation
- FSM states: IDLE, REQ, WAIT, EXEC, HALTED, TRAP.
- IDLE lasts one cycle after rst deasserts, then goes to REQ.
- REQ: ImemReq=1 for one cycle, then goes to WAIT. At most one request is outstanding.
- WAIT: on ImemValid=1, latch ImemData into Inst and go to EXEC. ImemValid is ignored in every other state.
- EXEC: InstValid=1 for exactly one cycle.
  - Target = {ALURes[31:1],1'b0} if NextPCSrc=1; otherwise PC+4.
  - If NextPCSrc=1 and target[1]=1: go to TRAP. Set MisalignTrap=1 and TrapPC=target. PC is held and RetireCount is not incremented.
  - Otherwise: PC<=target and RetireCount++. Go to HALTED if Halt=1, else REQ.
- Priority in EXEC: misalign trap > halt > normal.
- HALTED and TRAP are terminal until rst. ImemReq=0, InstValid=0, and Halted=1 in HALTED.
- Arithmetic: PCInc and RetireCount wrap modulo 2^32. PC 32'hFFFF_FFFC with NextPCSrc=0 goes to 32'h0000_0000.
- Halt is sampled only in EXEC.

## Timing
- Reset values: PC=RESET_PC, ImemAddr=RESET_PC, ImemReq=0, InstValid=0, Inst=32'h0000_0013 (NOP), MisalignTrap=0, TrapPC=0, Halted=0, RetireCount=0, state=IDLE.
- All outputs are registered except ImemAddr=PC and PCInc=PC+4, which are combinational from PC.
- Per-instruction latency is REQ(1) + WAIT(n) + EXEC(1), where n = memory latency ≥1. With n=1 this is 3 cycles per instruction.
- The first ImemReq is asserted in the second cycle after rst deasserts.
- ImemValid in the same cycle as ImemReq is not accepted. The earliest accepted response is the cycle after REQ.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). A response still in flight must be discarded by the memory reset. The unit does not filter stale responses arriving in WAIT.

## Structure
- Shared package core_pkg holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, EXEC, HALTED, TRAP)
  - NOP_INSTR = 32'h0000_0013
  - INSTR_BYTES = 4
- No sub-module. The FSM, PC register, and counter stay in one always_ff plus one always_comb.

## Test plan
- Reset/sequential fetch: RESET_PC=0, memory latency 1, NextPCSrc=0.
  - ImemAddr sequence is 0,4,8 at 3-cycle spacing.
  - InstValid pulses once per instruction.
  - RetireCount=3 after the third EXEC.
- Taken branch: at PC=32'h10 with NextPCSrc=1 and ALURes=32'h40, the next ImemAddr is 32'h40 and PCInc was 32'h14.
- JALR bit-0 clear: ALURes=32'h81 with NextPCSrc=1 gives next PC=32'h80 and no trap.
- Misaligned target: ALURes=32'h22 with NextPCSrc=1 and Halt=1 gives TRAP.
  - MisalignTrap=1, TrapPC=32'h22, Halted=0.
  - PC and RetireCount are unchanged, and there are no further ImemReq.
- Variable latency plus spurious strobe:
  - ImemValid pulsed during REQ is ignored.
  - A response arriving 5 cycles after the request is latched.
  - InstValid lasts 1 cycle.
- Halt and async reset:
  - Halt=1 in EXEC at PC=32'h8 gives Halted=1, PC=32'hC, and RetireCount incremented.
  - rst asserted mid-WAIT immediately clears the outputs to reset values, and fetch restarts at RESET_PC.
